// File: rtl/lightsaber_pkg.sv
// Shared definitions for the lightsaber blade-length controller.
//   - FSM state encoding (OFF/EXTENDING/ON/RETRACTING)
//   - Length limits (MAX_INT, MAX_DEC, MAX_CM)
//   - len_t: a blade length split into metres and centimetres
//   - to_cm / from_cm: conversion between the split form and total centimetres
package lightsaber_pkg;

   localparam int unsigned MAX_INT = 3;
   localparam int unsigned MAX_DEC = 99;
   localparam int unsigned MAX_CM  = 399;

   // Seven bits are needed to represent every centimetre value from 0 to 99,
   // and to recognise out-of-range requests such as 100.
   localparam int unsigned DEC_W = 7;

   localparam logic [1:0] ST_OFF        = 2'd0;
   localparam logic [1:0] ST_EXTENDING  = 2'd1;
   localparam logic [1:0] ST_ON         = 2'd2;
   localparam logic [1:0] ST_RETRACTING = 2'd3;

   typedef logic [8:0] cm_t;

   typedef struct packed {
      logic [1:0]       int_part;
      logic [DEC_W-1:0] dec_part;
   } len_t;

   function automatic cm_t to_cm(input logic [1:0] int_part, input logic [DEC_W-1:0] dec_part);
      return cm_t'(int_part) * cm_t'(100) + cm_t'(dec_part);
   endfunction

   // Caller guarantees cm <= MAX_CM.
   function automatic len_t from_cm(input cm_t cm);
      len_t r;
      if (cm >= cm_t'(300)) begin
         r.int_part = 2'd3;
         r.dec_part = DEC_W'(cm - cm_t'(300));
      end else if (cm >= cm_t'(200)) begin
         r.int_part = 2'd2;
         r.dec_part = DEC_W'(cm - cm_t'(200));
      end else if (cm >= cm_t'(100)) begin
         r.int_part = 2'd1;
         r.dec_part = DEC_W'(cm - cm_t'(100));
      end else begin
         r.int_part = 2'd0;
         r.dec_part = DEC_W'(cm);
      end
      return r;
   endfunction

endpackage

// File: rtl/length_step.sv
// length_step: combinational one-step ramp of the blade length.
// Ports:
//   i_up   - 1: extend toward i_tgt (clamped at i_tgt), 0: retract toward 0.
//   i_len  - current length (metres/centimetres).
//   i_tgt  - latched target length, used only when extending.
//   o_len  - length after one step of STEP centimetres, split exactly.
module length_step
   import lightsaber_pkg::*;
#(
   parameter int unsigned STEP = 1
) (
   input  logic i_up,
   input  len_t i_len,
   input  len_t i_tgt,
   output len_t o_len
);

   logic [9:0] w_cur;
   logic [9:0] w_tgt;
   logic [9:0] w_sum;
   logic [9:0] w_next;

   always_comb begin
      w_cur  = {1'b0, to_cm(i_len.int_part, i_len.dec_part)};
      w_tgt  = {1'b0, to_cm(i_tgt.int_part, i_tgt.dec_part)};
      w_sum  = w_cur + 10'(STEP);
      w_next = '0;
      if (i_up) begin
         w_next = (w_sum >= w_tgt) ? w_tgt : w_sum;
         if (w_next > 10'(MAX_CM)) begin
            w_next = 10'(MAX_CM);
         end
      end else begin
         w_next = (w_cur <= 10'(STEP)) ? 10'd0 : (w_cur - 10'(STEP));
      end
      o_len = from_cm(w_next[8:0]);
   end

endmodule

// File: rtl/lightsaber_length_ctrl.sv
// lightsaber_length_ctrl: blade extend/retract controller with a stepped length ramp.
// Ports:
//   i_clk, i_rst_n        - clock, asynchronous active-low reset.
//   i_ignite, i_retract   - one-cycle extend / retract requests (retract wins).
//   i_tgt_int, i_tgt_dec  - target length (metres, centimetres 0..99).
//   i_step_en             - ramp tick; length moves only when high.
//   o_len_int, o_len_dec  - current length, straight from the length register.
//   o_state               - OFF=0, EXTENDING=1, ON=2, RETRACTING=3.
//   o_blade_on            - state is not OFF.
//   o_done                - registered pulse on entry to ON or OFF.
//   o_err                 - registered pulse when an ignite is rejected.
module lightsaber_length_ctrl
   import lightsaber_pkg::*;
#(
   parameter int unsigned STEP = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_ignite,
   input  logic             i_retract,
   input  logic [1:0]       i_tgt_int,
   input  logic [DEC_W-1:0] i_tgt_dec,
   input  logic             i_step_en,
   output logic [1:0]       o_len_int,
   output logic [DEC_W-1:0] o_len_dec,
   output logic [1:0]       o_state,
   output logic             o_blade_on,
   output logic             o_done,
   output logic             o_err
);

   logic [1:0] r_state;
   logic [1:0] w_state_d;
   len_t       r_len;
   len_t       w_len_d;
   len_t       r_tgt;
   len_t       w_tgt_d;
   logic       r_done;
   logic       w_done_d;
   logic       r_err;
   logic       w_err_d;

   len_t       w_len_step;
   len_t       w_new_tgt;
   logic       w_tgt_valid;
   logic       w_ignite_only;

   assign w_new_tgt     = '{int_part: i_tgt_int, dec_part: i_tgt_dec};
   assign w_tgt_valid   = (i_tgt_dec <= DEC_W'(MAX_DEC)) &&
                          (to_cm(i_tgt_int, i_tgt_dec) != '0);
   // A simultaneous retract overrides ignite in every state.
   assign w_ignite_only = i_ignite && !i_retract;

   length_step #(
      .STEP (STEP)
   ) u_length_step (
      .i_up  (r_state != ST_RETRACTING),
      .i_len (r_len),
      .i_tgt (r_tgt),
      .o_len (w_len_step)
   );

   always_comb begin
      w_state_d = r_state;
      w_len_d   = r_len;
      w_tgt_d   = r_tgt;
      w_done_d  = 1'b0;
      w_err_d   = 1'b0;
      case (r_state)
         ST_OFF: begin
            if (w_ignite_only) begin
               if (w_tgt_valid) begin
                  w_tgt_d   = w_new_tgt;
                  w_state_d = ST_EXTENDING;
               end else begin
                  w_err_d = 1'b1;
               end
            end
         end
         ST_EXTENDING: begin
            if (i_retract) begin
               w_state_d = ST_RETRACTING;
            end else if (i_step_en) begin
               w_len_d = w_len_step;
               if (w_len_step == r_tgt) begin
                  w_state_d = ST_ON;
                  w_done_d  = 1'b1;
               end
            end
         end
         ST_ON: begin
            if (i_retract) begin
               w_state_d = ST_RETRACTING;
            end
         end
         ST_RETRACTING: begin
            if (w_ignite_only && w_tgt_valid) begin
               // Re-ignite: length holds this cycle, ramp resumes upward.
               w_tgt_d   = w_new_tgt;
               w_state_d = ST_EXTENDING;
            end else begin
               // A rejected ignite reports err but does not interrupt the ramp.
               w_err_d = w_ignite_only;
               if (i_step_en) begin
                  w_len_d = w_len_step;
                  if (w_len_step == '0) begin
                     w_state_d = ST_OFF;
                     w_done_d  = 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_OFF;
         r_len   <= '0;
         r_tgt   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_len   <= w_len_d;
         r_tgt   <= w_tgt_d;
         r_done  <= w_done_d;
         r_err   <= w_err_d;
      end
   end

   assign o_len_int  = r_len.int_part;
   assign o_len_dec  = r_len.dec_part;
   assign o_state    = r_state;
   assign o_blade_on = (r_state != ST_OFF);
   assign o_done     = r_done;
   assign o_err      = r_err;

endmodule

// File: tb/tb_lightsaber_length_ctrl.sv
// Directed self-checking bench for lightsaber_length_ctrl (STEP=1 and STEP=7 instances).
module tb_lightsaber_length_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ignite = 1'b0;
   logic       retract = 1'b0;
   logic [1:0] tgt_int = '0;
   logic [6:0] tgt_dec = '0;
   logic       step_en = 1'b0;

   logic [1:0] len_int, len_int7;
   logic [6:0] len_dec, len_dec7;
   logic [1:0] state, state7;
   logic       blade_on, blade_on7, done, done7, err, err7;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lightsaber_length_ctrl #(.STEP(1)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_ignite(ignite), .i_retract(retract),
      .i_tgt_int(tgt_int), .i_tgt_dec(tgt_dec), .i_step_en(step_en),
      .o_len_int(len_int), .o_len_dec(len_dec), .o_state(state),
      .o_blade_on(blade_on), .o_done(done), .o_err(err)
   );

   lightsaber_length_ctrl #(.STEP(7)) u_dut7 (
      .i_clk(clk), .i_rst_n(rst_n), .i_ignite(ignite), .i_retract(retract),
      .i_tgt_int(tgt_int), .i_tgt_dec(tgt_dec), .i_step_en(step_en),
      .o_len_int(len_int7), .o_len_dec(len_dec7), .o_state(state7),
      .o_blade_on(blade_on7), .o_done(done7), .o_err(err7)
   );

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ignite  = 1'b0;
      retract = 1'b0;
      step_en = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Check the STEP=1 instance: length, state, done, err.
   task automatic expect1(input string name, input int li, input int ld, input int st,
                          input bit dn, input bit er);
      checks++;
      if ({len_int, len_dec, state, done, err} !== {li[1:0], ld[6:0], st[1:0], dn, er}) begin
         errors++;
         $display("FAIL %s: got len=%0d.%02d state=%0d done=%0b err=%0b, want len=%0d.%02d state=%0d done=%0b err=%0b",
                  name, len_int, len_dec, state, done, err, li, ld, st, dn, er);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({len_int, len_dec, state, blade_on, done, err} !== 13'd0) begin
         errors++;
         $display("FAIL reset: got len=%0d.%02d state=%0d on=%0b done=%0b err=%0b, want all 0",
                  len_int, len_dec, state, blade_on, done, err);
      end
      apply_reset();
      expect1("reset_release", 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_extend_small();
      apply_reset();
      tgt_int = 2'd0; tgt_dec = 7'd3;
      ignite = 1'b1; step_en = 1'b1;
      tick();
      ignite = 1'b0;
      expect1("s1_ignite_hold", 0, 0, 1, 1'b0, 1'b0);
      tick();
      expect1("s1_len1", 0, 1, 1, 1'b0, 1'b0);
      tick();
      expect1("s1_len2", 0, 2, 1, 1'b0, 1'b0);
      tick();
      expect1("s1_len3_on", 0, 3, 2, 1'b1, 1'b0);
      tick();
      expect1("s1_done_single", 0, 3, 2, 1'b0, 1'b0);
      checks++;
      if (blade_on !== 1'b1) begin
         errors++;
         $display("FAIL s1_blade_on: got %0b want 1", blade_on);
      end
      idle_inputs();
   endtask

   task automatic test_carry_retract();
      apply_reset();
      tgt_int = 2'd1; tgt_dec = 7'd0;
      ignite = 1'b1;
      tick();
      ignite = 1'b0; step_en = 1'b1;
      repeat (99) tick();
      expect1("s2_len_0_99", 0, 99, 1, 1'b0, 1'b0);
      tick();
      expect1("s2_carry_1_00_on", 1, 0, 2, 1'b1, 1'b0);
      // ignite while ON is ignored
      tgt_int = 2'd2; ignite = 1'b1;
      tick();
      ignite = 1'b0; step_en = 1'b0;
      expect1("s2_on_ignore_ignite", 1, 0, 2, 1'b0, 1'b0);
      retract = 1'b1; step_en = 1'b1;
      tick();
      retract = 1'b0;
      expect1("s2_retract_hold", 1, 0, 3, 1'b0, 1'b0);
      tick();
      expect1("s2_borrow_0_99", 0, 99, 3, 1'b0, 1'b0);
      repeat (98) tick();
      expect1("s2_len_0_01", 0, 1, 3, 1'b0, 1'b0);
      tick();
      expect1("s2_off_done", 0, 0, 0, 1'b1, 1'b0);
      tick();
      expect1("s2_off_stays", 0, 0, 0, 1'b0, 1'b0);
      idle_inputs();
   endtask

   task automatic test_step7();
      apply_reset();
      tgt_int = 2'd0; tgt_dec = 7'd10;
      ignite = 1'b1;
      tick();
      ignite = 1'b0; step_en = 1'b1;
      tick();
      checks++;
      if ({len_int7, len_dec7, state7, done7} !== {2'd0, 7'd7, 2'd1, 1'b0}) begin
         errors++;
         $display("FAIL s3_len7: got len=%0d.%02d state=%0d done=%0b, want 0.07 state=1 done=0",
                  len_int7, len_dec7, state7, done7);
      end
      tick();
      checks++;
      if ({len_int7, len_dec7, state7, done7} !== {2'd0, 7'd10, 2'd2, 1'b1}) begin
         errors++;
         $display("FAIL s3_clamp: got len=%0d.%02d state=%0d done=%0b, want 0.10 state=2 done=1",
                  len_int7, len_dec7, state7, done7);
      end
      idle_inputs();
   endtask

   task automatic test_invalid();
      apply_reset();
      tgt_int = 2'd0; tgt_dec = 7'd100;
      ignite = 1'b1;
      tick();
      ignite = 1'b0;
      expect1("s4_err_dec100", 0, 0, 0, 1'b0, 1'b1);
      tick();
      expect1("s4_err_single", 0, 0, 0, 1'b0, 1'b0);
      tgt_dec = 7'd0;
      ignite = 1'b1;
      tick();
      ignite = 1'b0;
      expect1("s4_err_zero_tgt", 0, 0, 0, 1'b0, 1'b1);
      // both requests in OFF are ignored, even with a valid target
      tgt_dec = 7'd5; ignite = 1'b1; retract = 1'b1;
      tick();
      idle_inputs();
      expect1("s4_off_both_ignored", 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_ignite_retract_same();
      apply_reset();
      tgt_int = 2'd2; tgt_dec = 7'd0;
      ignite = 1'b1;
      tick();
      ignite = 1'b0; step_en = 1'b1;
      repeat (50) tick();
      expect1("s5_len_0_50", 0, 50, 1, 1'b0, 1'b0);
      ignite = 1'b1; retract = 1'b1;
      tick();
      ignite = 1'b0; retract = 1'b0;
      expect1("s5_retract_wins", 0, 50, 3, 1'b0, 1'b0);
      // invalid ignite while retracting: err and the ramp continues
      tgt_int = 2'd0; tgt_dec = 7'd120; ignite = 1'b1;
      tick();
      expect1("s5_ret_invalid", 0, 49, 3, 1'b0, 1'b1);
      // valid re-ignite: length holds, back to extending
      tgt_dec = 7'd51;
      tick();
      ignite = 1'b0;
      expect1("s5_reignite_hold", 0, 49, 1, 1'b0, 1'b0);
      tick();
      expect1("s5_reext_0_50", 0, 50, 1, 1'b0, 1'b0);
      tick();
      expect1("s5_reext_on", 0, 51, 2, 1'b1, 1'b0);
      idle_inputs();
   endtask

   task automatic test_ignite_in_extending();
      apply_reset();
      tgt_int = 2'd0; tgt_dec = 7'd5;
      ignite = 1'b1;
      tick();
      ignite = 1'b0; step_en = 1'b1;
      tick();
      // new target 0.02 must not be latched
      tgt_dec = 7'd2; ignite = 1'b1;
      tick();
      ignite = 1'b0;
      expect1("ext_ignore_ignite", 0, 2, 1, 1'b0, 1'b0);
      repeat (2) tick();
      expect1("ext_old_target_0_04", 0, 4, 1, 1'b0, 1'b0);
      tick();
      expect1("ext_old_target_on", 0, 5, 2, 1'b1, 1'b0);
      idle_inputs();
   endtask

   task automatic test_reset_mid_ramp();
      apply_reset();
      tgt_int = 2'd3; tgt_dec = 7'd99;
      ignite = 1'b1;
      tick();
      ignite = 1'b0; step_en = 1'b1;
      repeat (342) tick();
      expect1("s6_len_3_42", 3, 42, 1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({len_int, len_dec, state, blade_on} !== 11'd0) begin
         errors++;
         $display("FAIL s6_async_reset: got len=%0d.%02d state=%0d on=%0b, want 0.00 state=0 on=0",
                  len_int, len_dec, state, blade_on);
      end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      expect1("s6_after_release", 0, 0, 0, 1'b0, 1'b0);
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_extend_small();
      test_carry_retract();
      test_step7();
      test_invalid();
      test_ignite_retract_same();
      test_ignite_in_extending();
      test_reset_mid_ramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
